// File: rtl/seq_to_para_if.sv
// seq_to_para_if: serial-in / parallel-out bus bundle
// Signals: rdy (start pulse), data_in (serial word), data_out (assembled word),
//          done (completion pulse), busy (collection in progress)
// master drives rdy/data_in, slave (the deserializer) drives the rest.
interface seq_to_para_if #(
    parameter int RSA_LEN = 512,
    parameter int BUS_W   = 32
);
    logic               rdy;
    logic [BUS_W-1:0]   data_in;
    logic [RSA_LEN-1:0] data_out;
    logic               done;
    logic               busy;
    modport master (output rdy, data_in, input data_out, done, busy);
    modport slave  (input rdy, data_in, output data_out, done, busy);
endinterface

// File: rtl/seq_to_para.sv
// seq_to_para: collects RSA_LEN/BUS_W serial bus words into one parallel word
// Ports: clk, rst (sync, active-high), bus (seq_to_para_if.slave:
//        rdy, data_in in; data_out, done, busy out)
// Macro SEQ_TO_PARA_MSW_FIRST_EN: first received word lands in the top slice
//        instead of the bottom slice.
module seq_to_para #(
    parameter int RSA_LEN = 512,
    parameter int BUS_W   = 32
) (
    input logic          clk,
    input logic          rst,
    seq_to_para_if.slave bus
);
    localparam int WORDS = RSA_LEN / BUS_W;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [RSA_LEN-1:0] r_shreg;
    logic [RSA_LEN-1:0] r_data_out;
    logic               r_done;
    logic               r_busy;
    logic [RSA_LEN-1:0] w_next;
`ifdef SEQ_TO_PARA_MSW_FIRST_EN
    assign w_next = {r_shreg[RSA_LEN-BUS_W-1:0], bus.data_in};
`else
    assign w_next = {bus.data_in, r_shreg[RSA_LEN-1:BUS_W]};
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.rdy) begin
                    r_state <= COLLECT;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            end else begin
                // rdy is ignored while collecting
                r_shreg <= w_next;
                r_cnt   <= r_cnt + 1'b1;
                if (r_cnt == CW'(WORDS - 1)) begin
                    r_data_out <= w_next;
                    r_done     <= 1'b1;
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_cnt      <= '0;
                end
            end
        end
    end
    assign bus.data_out = r_data_out;
    assign bus.done     = r_done;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_seq_to_para.sv
// tb_seq_to_para: randomized + directed check of seq_to_para against a queue-based model
module tb_seq_to_para;
    localparam int RSA_LEN = 512;
    localparam int BUS_W   = 32;
    localparam int WORDS   = RSA_LEN / BUS_W;
    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   errs = 0;
    bit   chk_en = 1'b0;
    seq_to_para_if #(.RSA_LEN(RSA_LEN), .BUS_W(BUS_W)) bus ();
    seq_to_para #(.RSA_LEN(RSA_LEN), .BUS_W(BUS_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    // slot of the i-th received word inside data_out
    function automatic int slot(input int i);
`ifdef SEQ_TO_PARA_MSW_FIRST_EN
        return WORDS - 1 - i;
`else
        return i;
`endif
    endfunction
    task automatic chk(input string name, input logic [RSA_LEN-1:0] act, input logic [RSA_LEN-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // reference model: words gathered in a queue, value built by arithmetic on completion
    logic [BUS_W-1:0]   q[$];
    bit                 m_coll = 1'b0;
    logic               m_busy = 1'b0;
    logic               m_done = 1'b0;
    logic [RSA_LEN-1:0] m_out = '0;
    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_coll = 1'b0;
            m_busy = 1'b0;
            m_out  = '0;
            q.delete();
        end else if (!m_coll) begin
            if (bus.rdy) begin
                m_coll = 1'b1;
                m_busy = 1'b1;
                q.delete();
            end
        end else begin
            q.push_back(bus.data_in);
            if (q.size() == WORDS) begin
                m_out = '0;
                for (int i = 0; i < WORDS; i++)
                    m_out = m_out | (RSA_LEN'(q[i]) << (BUS_W * slot(i)));
                m_done = 1'b1;
                m_coll = 1'b0;
                m_busy = 1'b0;
            end
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            chk("done", RSA_LEN'(bus.done), RSA_LEN'(m_done));
            chk("busy", RSA_LEN'(bus.busy), RSA_LEN'(m_busy));
            chk("data_out", bus.data_out, m_out);
        end
    end
    function automatic logic [RSA_LEN-1:0] mk(input logic [BUS_W-1:0] base);
        logic [RSA_LEN-1:0] v = '0;
        for (int i = 0; i < WORDS; i++) v[BUS_W*i +: BUS_W] = base + BUS_W'(i);
        return v;
    endfunction
    // caller raises rdy at a negedge; w holds words in send order
    task automatic collect(input logic [RSA_LEN-1:0] w, input int rdy_again, input int rst_at,
                           input bit chain, output int done_at, output int busy_cnt);
        done_at  = -1;
        busy_cnt = 0;
        for (int k = 1; k <= WORDS + 1; k++) begin
            @(negedge clk);
            if (bus.done && done_at < 0) done_at = k;
            if (bus.busy) busy_cnt++;
            bus.rdy     = (k == rdy_again) || (k == WORDS + 1 && chain);
            rst         = (k == rst_at);
            bus.data_in = (k <= WORDS) ? w[BUS_W*(k-1) +: BUS_W] : BUS_W'($urandom);
        end
    endtask
    int                 d, b;
    logic [RSA_LEN-1:0] x, w;
    logic [BUS_W-1:0]   base;
    initial begin
        rst = 1'b1;
        bus.rdy = 1'b0;
        bus.data_in = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_data_out", bus.data_out, '0);
        chk("rst_done", RSA_LEN'(bus.done), '0);
        chk("rst_busy", RSA_LEN'(bus.busy), '0);
        rst = 1'b0;
        bus.rdy = 1'b1;
        collect(mk(32'h0), -1, -1, 1'b1, d, b);
        chk("basic_latency", RSA_LEN'(d), RSA_LEN'(17));
        chk("basic_busy_cycles", RSA_LEN'(b), RSA_LEN'(16));
`ifdef SEQ_TO_PARA_MSW_FIRST_EN
        chk("basic_hi", RSA_LEN'(bus.data_out[511:480]), RSA_LEN'(32'h0));
        chk("basic_lo", RSA_LEN'(bus.data_out[31:0]), RSA_LEN'(32'hF));
`else
        chk("basic_lo", RSA_LEN'(bus.data_out[31:0]), RSA_LEN'(32'h0));
        chk("basic_hi", RSA_LEN'(bus.data_out[511:480]), RSA_LEN'(32'hF));
`endif
        collect(mk(32'hA000_0000), -1, -1, 1'b0, d, b);
        chk("b2b_latency", RSA_LEN'(d), RSA_LEN'(17));
        chk("b2b_first_word", RSA_LEN'(bus.data_out[BUS_W*slot(0) +: BUS_W]), RSA_LEN'(32'hA000_0000));
        repeat (2) @(negedge clk);
        bus.rdy = 1'b1;
        collect(mk(32'h5000_0000), 6, -1, 1'b0, d, b);
        chk("repulse_latency", RSA_LEN'(d), RSA_LEN'(17));
        chk("repulse_word5", RSA_LEN'(bus.data_out[BUS_W*slot(5) +: BUS_W]), RSA_LEN'(32'h5000_0005));
        chk("repulse_word15", RSA_LEN'(bus.data_out[BUS_W*slot(15) +: BUS_W]), RSA_LEN'(32'h5000_000F));
        @(negedge clk);
        bus.rdy = 1'b1;
        collect(mk(32'h7000_0000), -1, 9, 1'b0, d, b);
        chk("rst_abort_no_done", RSA_LEN'(d), RSA_LEN'(-1));
        chk("rst_abort_data_out", bus.data_out, '0);
        base = BUS_W'($urandom);
        bus.rdy = 1'b1;
        collect(mk(base), -1, -1, 1'b0, d, b);
        chk("after_rst_latency", RSA_LEN'(d), RSA_LEN'(17));
        chk("after_rst_word0", RSA_LEN'(bus.data_out[BUS_W*slot(0) +: BUS_W]), RSA_LEN'(base));
        for (int i = 0; i < RSA_LEN / 32; i++) x[32*i +: 32] = $urandom;
        for (int i = 0; i < WORDS; i++) w[BUS_W*i +: BUS_W] = x[BUS_W*slot(i) +: BUS_W];
        bus.rdy = 1'b1;
        collect(w, -1, -1, 1'b0, d, b);
        chk("loopback", bus.data_out, x);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            bus.rdy     = ($urandom_range(0, 3) == 0);
            bus.data_in = BUS_W'($urandom);
            rst         = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.rdy = 1'b0;
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
